// File: rtl/haraka_s_absorb_padder.sv
// haraka_s_absorb_padder
//   Upstream stage of the Haraka-S sponge core. Packs a byte stream into
//   RATE_BYTES-wide rate blocks and applies sponge padding: DOMAIN_BYTE is
//   XORed after the last message byte and FINAL_BYTE into the last rate byte.
//   Each block is presented on a valid/ready handshake, and the final block of
//   a message is flagged so the core can switch to squeezing.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset
//   in_data_i      message byte
//   in_valid_i     in_data_i/in_keep_i/in_last_i valid this cycle
//   in_keep_i      1 = in_data_i carries a byte, 0 = terminator only
//   in_last_i      end of message
//   in_ready_o     padder accepts input this cycle (FILL only)
//   block_data_o   padded rate block, byte i at [8i+7:8i]
//   block_valid_o  block_data_o valid
//   block_last_o   final block of the message, qualified by block_valid_o
//   block_ready_i  consumer accepts the block
//   byte_count_o   message bytes accepted since reset or message end
//
// state  | meaning
// FILL   | accepting input bytes into the buffer
// HOLD   | presenting a block, waiting for block_ready_i
// PADBLK | one cycle: load the all-padding block after a full final block
module haraka_s_absorb_padder #(
  parameter int          RATE_BYTES  = 32,
  parameter logic [7:0]  DOMAIN_BYTE = 8'h1F,
  parameter logic [7:0]  FINAL_BYTE  = 8'h80
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              in_data_i,
  input  logic                    in_valid_i,
  input  logic                    in_keep_i,
  input  logic                    in_last_i,
  output logic                    in_ready_o,
  output logic [8*RATE_BYTES-1:0] block_data_o,
  output logic                    block_valid_o,
  output logic                    block_last_o,
  input  logic                    block_ready_i,
  output logic [63:0]             byte_count_o
);

  localparam int             IW       = $clog2(RATE_BYTES);
  localparam logic [IW-1:0]  LAST_IDX = IW'(RATE_BYTES - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    PADBLK = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [RATE_BYTES-1:0][7:0]   buf_q, buf_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [IW-1:0]                idx_inc;
  logic                         last_q, last_d;
  logic                         pad_q, pad_d;
  logic [63:0]                  cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FILL;
      buf_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx_inc = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    last_d  = last_q;
    pad_d   = pad_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (in_valid_i) begin
          if (in_keep_i) begin
            buf_d[idx_q] = in_data_i;
            idx_d        = idx_inc;
            cnt_d        = cnt_q + 64'd1;
            if (idx_q == LAST_IDX) begin
              // Full block: padding, if due, goes in a separate block.
              state_d = HOLD;
              last_d  = 1'b0;
              pad_d   = in_last_i;
            end else if (in_last_i) begin
              // Both XORs may hit the same byte, giving DOMAIN^FINAL.
              buf_d[idx_inc]  = buf_d[idx_inc] ^ DOMAIN_BYTE;
              buf_d[LAST_IDX] = buf_d[LAST_IDX] ^ FINAL_BYTE;
              last_d          = 1'b1;
              state_d         = HOLD;
            end
          end else if (in_last_i) begin
            buf_d[idx_q]    = buf_d[idx_q] ^ DOMAIN_BYTE;
            buf_d[LAST_IDX] = buf_d[LAST_IDX] ^ FINAL_BYTE;
            last_d          = 1'b1;
            state_d         = HOLD;
          end
        end
      end
      HOLD: begin
        if (block_ready_i) begin
          buf_d  = '0;
          idx_d  = '0;
          last_d = 1'b0;
          if (pad_q) begin
            pad_d   = 1'b0;
            state_d = PADBLK;
          end else begin
            if (last_q) cnt_d = '0;
            state_d = FILL;
          end
        end
      end
      PADBLK: begin
        buf_d           = '0;
        buf_d[0]        = DOMAIN_BYTE;
        buf_d[LAST_IDX] = FINAL_BYTE;
        last_d          = 1'b1;
        state_d         = HOLD;
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready_o    = (state_q == FILL) && !reset_i;
  assign block_valid_o = (state_q == HOLD);
  assign block_last_o  = last_q;
  assign block_data_o  = buf_q;
  assign byte_count_o  = cnt_q;

endmodule

// File: tb/tb_haraka_s_absorb_padder.sv
// Directed bench for haraka_s_absorb_padder: empty, short, 31/32/40-byte
// messages, ignored beats, back-pressure and reset while holding a block.
module tb_haraka_s_absorb_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_keep;
  logic         in_last;
  logic         in_ready;
  logic [255:0] block_data;
  logic         block_valid;
  logic         block_last;
  logic         block_ready;
  logic [63:0]  byte_count;

  int vecs = 0;
  int errs = 0;
  logic [255:0] exp;

  always #5 clk = ~clk;

  haraka_s_absorb_padder dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_keep_i     (in_keep),
    .in_last_i     (in_last),
    .in_ready_o    (in_ready),
    .block_data_o  (block_data),
    .block_valid_o (block_valid),
    .block_last_o  (block_last),
    .block_ready_i (block_ready),
    .byte_count_o  (byte_count)
  );

  // Drive one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic k, input logic l);
    int n = 0;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (!in_ready) begin
      errs++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_keep  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handoff();
    block_ready = 1'b1;
    @(posedge clk); #1;
    block_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    in_data = 8'h00; block_ready = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready_during: got %b want 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready_after: got %b want 1", in_ready); end
    vecs++;
    if (block_valid !== 1'b0 || block_last !== 1'b0) begin
      errs++; $display("FAIL rst_valid_last: got %b%b want 00", block_valid, block_last);
    end
    vecs++;
    if (byte_count !== 64'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", byte_count); end
    vecs++;
    if (block_data !== 256'd0) begin errs++; $display("FAIL rst_data: got %h want 0", block_data); end
  endtask

  task automatic test_empty();
    send(8'h00, 1'b0, 1'b1);
    exp = '0; exp[7:0] = 8'h1F; exp[255:248] = 8'h80;
    vecs++;
    if (block_valid !== 1'b1 || in_ready !== 1'b0) begin
      errs++; $display("FAIL empty_valid: valid=%b ready=%b want 1 0", block_valid, in_ready);
    end
    vecs++;
    if (block_data !== exp || block_last !== 1'b1) begin
      errs++; $display("FAIL empty_block: got %h last=%b want %h last=1", block_data, block_last, exp);
    end
    vecs++;
    if (byte_count !== 64'd0) begin errs++; $display("FAIL empty_count: got %0d want 0", byte_count); end
    handoff();
    vecs++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL empty_after: valid=%b ready=%b want 0 1", block_valid, in_ready);
    end
  endtask

  task automatic test_abc();
    send(8'h61, 1'b1, 1'b0);
    send(8'h62, 1'b1, 1'b0);
    send(8'h63, 1'b1, 1'b1);
    exp = '0;
    exp[7:0] = 8'h61; exp[15:8] = 8'h62; exp[23:16] = 8'h63; exp[31:24] = 8'h1F;
    exp[255:248] = 8'h80;
    vecs++;
    if (block_valid !== 1'b1 || block_last !== 1'b1) begin
      errs++; $display("FAIL abc_valid_last: got %b%b want 11", block_valid, block_last);
    end
    vecs++;
    if (block_data !== exp) begin errs++; $display("FAIL abc_block: got %h want %h", block_data, exp); end
    vecs++;
    if (byte_count !== 64'd3) begin errs++; $display("FAIL abc_count: got %0d want 3", byte_count); end
    handoff();
    vecs++;
    if (byte_count !== 64'd0) begin errs++; $display("FAIL abc_count_clr: got %0d want 0", byte_count); end
  endtask

  task automatic test_ignored_beat();
    send(8'h11, 1'b1, 1'b0);
    send(8'hEE, 1'b0, 1'b0);
    vecs++;
    if (block_valid !== 1'b0 || byte_count !== 64'd1 || in_ready !== 1'b1) begin
      errs++; $display("FAIL ign_beat: valid=%b count=%0d ready=%b want 0 1 1", block_valid, byte_count, in_ready);
    end
    send(8'h22, 1'b1, 1'b1);
    exp = '0; exp[7:0] = 8'h11; exp[15:8] = 8'h22; exp[23:16] = 8'h1F; exp[255:248] = 8'h80;
    vecs++;
    if (block_data !== exp || block_last !== 1'b1) begin
      errs++; $display("FAIL ign_block: got %h last=%b want %h last=1", block_data, block_last, exp);
    end
    handoff();
  endtask

  task automatic test_31();
    for (int i = 0; i < 31; i++) send(8'(i), 1'b1, (i == 30));
    exp = '0;
    for (int i = 0; i < 31; i++) exp[8*i +: 8] = 8'(i);
    exp[255:248] = 8'h9F;
    vecs++;
    if (block_data !== exp || block_last !== 1'b1 || block_valid !== 1'b1) begin
      errs++; $display("FAIL b31_block: got %h last=%b valid=%b want %h 1 1", block_data, block_last, block_valid, exp);
    end
    vecs++;
    if (byte_count !== 64'd31) begin errs++; $display("FAIL b31_count: got %0d want 31", byte_count); end
    handoff();
  endtask

  task automatic test_32();
    for (int i = 0; i < 32; i++) send(8'(i), 1'b1, (i == 31));
    exp = '0;
    for (int i = 0; i < 32; i++) exp[8*i +: 8] = 8'(i);
    vecs++;
    if (block_data !== exp || block_last !== 1'b0 || block_valid !== 1'b1) begin
      errs++; $display("FAIL b32_blockA: got %h last=%b valid=%b want %h 0 1", block_data, block_last, block_valid, exp);
    end
    vecs++;
    if (in_ready !== 1'b0 || byte_count !== 64'd32) begin
      errs++; $display("FAIL b32_holdA: ready=%b count=%0d want 0 32", in_ready, byte_count);
    end
    handoff();
    vecs++;
    if (in_ready !== 1'b0 || block_valid !== 1'b0) begin
      errs++; $display("FAIL b32_padcycle: ready=%b valid=%b want 0 0", in_ready, block_valid);
    end
    @(posedge clk); #1;
    exp = '0; exp[7:0] = 8'h1F; exp[255:248] = 8'h80;
    vecs++;
    if (block_data !== exp || block_last !== 1'b1 || block_valid !== 1'b1 || in_ready !== 1'b0) begin
      errs++; $display("FAIL b32_blockB: got %h last=%b valid=%b ready=%b want %h 1 1 0",
                       block_data, block_last, block_valid, in_ready, exp);
    end
    vecs++;
    if (byte_count !== 64'd32) begin errs++; $display("FAIL b32_countB: got %0d want 32", byte_count); end
    handoff();
    vecs++;
    if (byte_count !== 64'd0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL b32_after: count=%0d ready=%b want 0 1", byte_count, in_ready);
    end
  endtask

  task automatic test_back_to_back_stall();
    for (int i = 0; i < 32; i++) send(8'h40 + 8'(i), 1'b1, 1'b0);
    exp = '0;
    for (int i = 0; i < 32; i++) exp[8*i +: 8] = 8'h40 + 8'(i);
    for (int c = 0; c < 5; c++) begin
      vecs++;
      if (block_data !== exp || block_valid !== 1'b1 || block_last !== 1'b0 || in_ready !== 1'b0) begin
        errs++; $display("FAIL stall_blk1 c%0d: got %h v=%b l=%b r=%b want %h 1 0 0",
                         c, block_data, block_valid, block_last, in_ready, exp);
      end
      @(posedge clk); #1;
    end
    handoff();
    for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 1'b1, (i == 7));
    exp = '0;
    for (int i = 0; i < 8; i++) exp[8*i +: 8] = 8'h60 + 8'(i);
    exp[71:64] = 8'h1F; exp[255:248] = 8'h80;
    vecs++;
    if (byte_count !== 64'd40) begin errs++; $display("FAIL stall_count: got %0d want 40", byte_count); end
    for (int c = 0; c < 5; c++) begin
      vecs++;
      if (block_data !== exp || block_valid !== 1'b1 || block_last !== 1'b1 || in_ready !== 1'b0) begin
        errs++; $display("FAIL stall_blk2 c%0d: got %h v=%b l=%b r=%b want %h 1 1 0",
                         c, block_data, block_valid, block_last, in_ready, exp);
      end
      @(posedge clk); #1;
    end
    handoff();
  endtask

  task automatic test_reset_in_hold();
    for (int i = 0; i < 10; i++) send(8'hA0 + 8'(i), 1'b1, (i == 9));
    vecs++;
    if (block_valid !== 1'b1 || byte_count !== 64'd10) begin
      errs++; $display("FAIL rhold_pre: valid=%b count=%0d want 1 10", block_valid, byte_count);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (block_valid !== 1'b0 || block_last !== 1'b0 || byte_count !== 64'd0 || block_data !== 256'd0) begin
      errs++; $display("FAIL rhold_post: valid=%b last=%b count=%0d data=%h want 0 0 0 0",
                       block_valid, block_last, byte_count, block_data);
    end
    reset = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL rhold_ready: got %b want 1", in_ready); end
    test_abc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_ignored_beat();
    test_31();
    test_32();
    test_back_to_back_stall();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
